// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the 32 x 32-bit register file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    // Index of the last register touched by a bulk clear
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_5_32.sv
// 5-to-32 one-hot address decoder feeding the per-register write enables.
module decoder_5_32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // Exactly one bit set, selected by addr_i
    always_comb begin
        onehot_o = '0;
        onehot_o[addr_i] = 1'b1;
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit register file: two registered read ports, one write port,
// hard-wired zero register and a sequenced bulk clear.
// Optional build macro REGFILE_BYPASS_EN enables write-through forwarding.
module register_file
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Ardr1,
    input  logic [ADDR_W-1:0] Ardr2,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              WrEn,
    input  logic              Clr,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2,
    output logic              Busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   dout1_q, dout1_d;
    logic [DATA_W-1:0]   dout2_q, dout2_d;

    logic [NUM_REGS-1:0] dec_onehot;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] clr_sel;
    logic                wr_ok;

    decoder_5_32 u_dec (
        .addr_i   (Awr),
        .onehot_o (dec_onehot)
    );

    // A write is only honoured while no bulk clear is running
    assign wr_ok  = WrEn && (state_q == IDLE);
    assign wr_sel = dec_onehot & {NUM_REGS{wr_ok}};

    // Clear sequencer: walks cnt from 1 to 31, one register per edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_sel = '0;
        unique case (state_q)
            IDLE: begin
                if (Clr) begin
                    state_d = CLEAR;
                    cnt_d   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                clr_sel[cnt_q] = 1'b1;
                cnt_d          = ADDR_W'(cnt_q + ADDR_W'(1));
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and clear counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next storage contents: clear wins over write, register 0 stays zero
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_sel[i]) begin
                regs_d[i] = '0;
            end else if (wr_sel[i]) begin
                regs_d[i] = Din;
            end
        end
        regs_d[0] = '0;
    end

    // Storage array
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read-port data selection, including same-edge forwarding when enabled
    always_comb begin
        dout1_d = (Ardr1 == '0) ? '0 : regs_q[Ardr1];
        dout2_d = (Ardr2 == '0) ? '0 : regs_q[Ardr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (Awr != '0) && (Ardr1 == Awr)) begin
            dout1_d = Din;
        end else if ((state_q == CLEAR) && (Ardr1 == cnt_q)) begin
            dout1_d = '0;
        end
        if (wr_ok && (Awr != '0) && (Ardr2 == Awr)) begin
            dout2_d = Din;
        end else if ((state_q == CLEAR) && (Ardr2 == cnt_q)) begin
            dout2_d = '0;
        end
`endif
    end

    // Registered read data
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dout1_q <= '0;
            dout2_q <= '0;
        end else begin
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
        end
    end

    assign Dout1 = dout1_q;
    assign Dout2 = dout2_q;
    assign Busy  = (state_q == CLEAR);

endmodule
